level_seq: RTL and testbench

Parametrised multi-level sequencer, successor to the fixed two-level start/mode FSM. On `start` it walks, in ascending index order, through every level enabled in a captured mask, dwelling a programmable number of cycles in each. It then reports completion. It sits between the mode/configuration registers and the per-level datapath enables, and supports clock-enable gating and abort.

---
 rtl/level_seq_pkg.sv | 18 +
 rtl/level_seq_pick.sv | 32 +++
 rtl/level_seq.sv | 147 ++++++++++++++
 tb/tb_level_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/level_seq_pkg.sv
// +--------------------------------------------------------------------------+
// | level_seq_pkg : shared state encoding for the multi-level sequencer      |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

package level_seq_pkg;

  // 2'd3 is never produced; the top recovers it to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } st_t;

endpackage

`default_nettype wire

// File: rtl/level_seq_pick.sv
// +--------------------------------------------------------------------------+
// | level_seq_pick : finds the lowest enabled level above cur_idx            |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module level_seq_pick #(
  parameter int NUM_LVL = 4,
  parameter int IDX_W   = $clog2(NUM_LVL)
) (
  input  logic [NUM_LVL-1:0] mask,
  input  logic [IDX_W-1:0]   cur_idx,
  input  logic               first,
  output logic               found,
  output logic [IDX_W-1:0]   nxt_idx
);

  // Scanning high to low lets the lowest qualifying bit overwrite the rest.
  always_comb begin
    found   = 1'b0;
    nxt_idx = '0;
    for (int i = NUM_LVL - 1; i >= 0; i--) begin
      if (mask[i] && (first || (IDX_W'(i) > cur_idx))) begin
        found   = 1'b1;
        nxt_idx = IDX_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/level_seq.sv
// +--------------------------------------------------------------------------+
// | level_seq : walks enabled levels in ascending order with per-level dwell |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module level_seq
  import level_seq_pkg::*;
#(
  parameter int NUM_LVL = 4,
  parameter int CNT_W   = 8,
  parameter int IDX_W   = $clog2(NUM_LVL)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clken,
  input  logic                     start,
  input  logic                     abort,
  input  logic [NUM_LVL-1:0]       lvl_en,
  input  logic [NUM_LVL*CNT_W-1:0] lvl_len,
  output logic                     busy,
  output logic [NUM_LVL-1:0]       lvl_act,
  output logic [IDX_W-1:0]         lvl_idx,
  output logic [CNT_W-1:0]         cnt,
  output logic                     done,
  output logic                     aborted
);

  st_t                     state_q, state_d;
  logic [NUM_LVL-1:0]       en_q, en_d;
  logic [NUM_LVL*CNT_W-1:0] len_q, len_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     aborted_q, aborted_d;

  logic                     in_idle;
  logic [NUM_LVL-1:0]       pick_mask;
  logic                     pick_found;
  logic [IDX_W-1:0]         pick_idx;
  logic [CNT_W-1:0]         cap_len [NUM_LVL];
  logic [CNT_W-1:0]         run_len [NUM_LVL];

  generate
    for (genvar k = 0; k < NUM_LVL; k++) begin : g_len
      assign cap_len[k] = lvl_len[k*CNT_W +: CNT_W];
      assign run_len[k] = len_q[k*CNT_W +: CNT_W];
    end
  endgenerate

  // In IDLE the search runs on the live mask so the first level is known at start.
  assign in_idle   = (state_q == ST_IDLE);
  assign pick_mask = in_idle ? lvl_en : en_q;

  level_seq_pick #(
    .NUM_LVL (NUM_LVL),
    .IDX_W   (IDX_W)
  ) u_pick (
    .mask    (pick_mask),
    .cur_idx (idx_q),
    .first   (in_idle),
    .found   (pick_found),
    .nxt_idx (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    aborted_d = aborted_q;
    if (clken) begin
      aborted_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            en_d  = lvl_en;
            len_d = lvl_len;
            if (pick_found) begin
              state_d = ST_RUN;
              idx_d   = pick_idx;
              cnt_d   = cap_len[pick_idx];
            end else begin
              state_d = ST_DONE;
              idx_d   = '0;
              cnt_d   = '0;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_d   = ST_IDLE;
            idx_d     = '0;
            cnt_d     = '0;
            aborted_d = 1'b1;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (pick_found) begin
            idx_d = pick_idx;
            cnt_d = run_len[pick_idx];
          end else begin
            state_d = ST_DONE;
            idx_d   = '0;
          end
        end
        ST_DONE: begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          aborted_d = abort;
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      en_q      <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      aborted_q <= aborted_d;
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign lvl_idx = busy ? idx_q : '0;
  assign lvl_act = busy ? (NUM_LVL'(1) << idx_q) : '0;
  assign cnt     = cnt_q;
  assign aborted = aborted_q;

endmodule

`default_nettype wire

// File: tb/tb_level_seq.sv
// +--------------------------------------------------------------------------+
// | tb_level_seq : scoreboard bench for level_seq against a sequence model   |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_level_seq;

  localparam int NUM_LVL = 4;
  localparam int CNT_W   = 8;
  localparam int IDX_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst_n, clken, start, abort;
  logic [NUM_LVL-1:0]       lvl_en;
  logic [NUM_LVL*CNT_W-1:0] lvl_len;
  logic                     busy, done, aborted;
  logic [NUM_LVL-1:0]       lvl_act;
  logic [IDX_W-1:0]         lvl_idx;
  logic [CNT_W-1:0]         cnt;

  level_seq #(.NUM_LVL(NUM_LVL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clken(clken), .start(start), .abort(abort),
    .lvl_en(lvl_en), .lvl_len(lvl_len), .busy(busy), .lvl_act(lvl_act),
    .lvl_idx(lvl_idx), .cnt(cnt), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  typedef struct { bit busy; int idx; int cnt; bit done; bit ab; } exp_t;
  typedef struct { int idx; int cnt; } step_t;

  exp_t  expq[$];
  step_t plan[$];
  int    mode = 0;          // 0 idle, 1 running, 2 done
  int    n_tot = 0;
  int    n_bad = 0;
  exp_t  last = '{0, 0, 0, 0, 0};
  bit    ce_s, rn_s;

  // Reference: the whole run is a flat list of (level, remaining) pairs built at start.
  task automatic model_edge();
    exp_t  e;
    step_t s;
    e = '{0, 0, 0, 0, 0};
    if (!rst_n) begin
      mode = 0;
      plan.delete();
    end else if (!clken) begin
      return;
    end else begin
      case (mode)
        0: if (start) begin
          plan.delete();
          for (int k = 0; k < NUM_LVL; k++)
            if (lvl_en[k])
              for (int c = int'(lvl_len[k*CNT_W +: CNT_W]); c >= 0; c--)
                plan.push_back('{k, c});
          if (plan.size() == 0) begin
            mode = 2; e.done = 1;
          end else begin
            mode = 1; s = plan.pop_front();
            e.busy = 1; e.idx = s.idx; e.cnt = s.cnt;
          end
        end
        1: if (abort) begin
          mode = 0; plan.delete(); e.ab = 1;
        end else if (plan.size() != 0) begin
          s = plan.pop_front();
          e.busy = 1; e.idx = s.idx; e.cnt = s.cnt;
        end else begin
          mode = 2; e.done = 1;
        end
        default: begin
          mode = 0; e.ab = abort;
        end
      endcase
    end
    expq.push_back(e);
  endtask

  task automatic cyc(input bit s, input bit a, input bit ce, input bit rn,
                     input logic [NUM_LVL-1:0] en, input logic [NUM_LVL*CNT_W-1:0] len);
    @(negedge clk);
    start = s; abort = a; clken = ce; rst_n = rn; lvl_en = en; lvl_len = len;
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 1, '0, '0);
  endtask

  task automatic check(input exp_t e, input string tag);
    logic [NUM_LVL-1:0] act_e;
    act_e = e.busy ? (NUM_LVL'(1) << e.idx) : '0;
    n_tot++;
    if (busy !== e.busy || done !== e.done || aborted !== e.ab || lvl_act !== act_e ||
        lvl_idx !== IDX_W'(e.idx) || cnt !== CNT_W'(e.cnt)) begin
      n_bad++;
      $display("FAIL %s t=%0t got/exp busy=%b/%b idx=%0d/%0d cnt=%0d/%0d act=%b/%b done=%b/%b aborted=%b/%b",
               tag, $time, busy, e.busy, lvl_idx, e.idx, cnt, e.cnt, lvl_act, act_e,
               done, e.done, aborted, e.ab);
    end
  endtask

  // Monitor: every qualified edge yields one scoreboard entry; gated edges must hold.
  initial begin
    forever begin
      @(posedge clk);
      ce_s = clken;
      rn_s = rst_n;
      #1;
      if (!rn_s || ce_s) begin
        if (expq.size() == 0) begin
          n_tot++; n_bad++;
          $display("FAIL underflow t=%0t got busy=%b done=%b required an expectation entry", $time, busy, done);
        end else begin
          last = expq.pop_front();
          check(last, "qualified");
        end
      end else begin
        check(last, "gated_hold");
      end
    end
  end

  localparam logic [31:0] L0123 = 32'h03020100;
  localparam logic [31:0] L2222 = 32'h02020202;

  initial begin
    rst_n = 0; clken = 0; start = 0; abort = 0; lvl_en = '0; lvl_len = '0;
    model_edge();
    cyc(1, 0, 1, 0, 4'hF, L0123);
    idle(2);

    // Full walk, 10 run cycles then done.
    cyc(1, 0, 1, 1, 4'hF, L0123);
    idle(13);
    // Sparse mask 1010.
    cyc(1, 0, 1, 1, 4'b1010, L2222);
    idle(9);
    // Zero mask goes straight to done.
    cyc(1, 0, 1, 1, 4'b0000, L2222);
    idle(3);
    // Abort on the third run cycle.
    cyc(1, 0, 1, 1, 4'hF, L0123);
    cyc(0, 0, 1, 1, '0, '0);
    cyc(0, 1, 1, 1, '0, '0);
    idle(4);
    // Abort coincident with start in idle: start wins.
    cyc(1, 1, 1, 1, 4'hF, L0123);
    idle(13);
    // Gated clken pattern with mid-run length changes.
    cyc(1, 0, 1, 1, 4'hF, L0123);
    for (int i = 1; i < 40; i++)
      cyc(0, 0, (i % 3) == 0, 1, 4'h0, $urandom);
    idle(3);
    // Start held high: ignored in done, accepted again after.
    for (int i = 0; i < 16; i++) cyc(1, 0, 1, 1, 4'b0110, 32'h00010100);
    idle(4);
    // Reset during run with start asserted.
    cyc(1, 0, 1, 1, 4'hF, L0123);
    idle(2);
    cyc(1, 0, 1, 0, 4'hF, L0123);
    cyc(1, 0, 1, 0, 4'hF, L0123);
    idle(3);
    // Abort while in done.
    cyc(1, 0, 1, 1, 4'b0001, 32'h0);
    cyc(0, 0, 1, 1, '0, '0);
    cyc(0, 1, 1, 1, '0, '0);
    idle(3);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] l;
      for (int k = 0; k < NUM_LVL; k++) l[k*8 +: 8] = 8'($urandom_range(0, 4));
      cyc($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5,
          $urandom_range(0, 99) < 75, $urandom_range(0, 99) > 1,
          4'($urandom), l);
    end
    idle(20);

    @(posedge clk);
    #2;
    n_tot++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain leftover=%0d required=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
